// File: rtl/nibble_packer.sv
// nibble_packer: packs K N-bit valid/ready beats into one K*N-bit word.
// Ports: clk, rst (sync, active-high); beat side valid_i/data_i/last_i/ready_o;
// word side valid_o/data_o/beats_o/ready_i. The first beat lands in the low slot.
module nibble_packer #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int CW = $clog2(K+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [N-1:0]    data_i,
  input  logic            last_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [K*N-1:0]  data_o,
  output logic [CW-1:0]   beats_o,
  input  logic            ready_i
);

  localparam logic [CW-1:0] LAST = CW'(K-1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [K*N-1:0] acc_q, acc_d;
  logic           valid_q, valid_d;
  logic [K*N-1:0] data_q, data_d;
  logic [CW-1:0]  beats_q, beats_d;

  logic           closing;
  logic           fire;
  logic [K*N-1:0] word;

  // A closing beat needs the output register free or draining;
  // non-closing beats only touch the accumulator.
  assign closing = (cnt_q == LAST) || last_i;
  assign ready_o = !closing || !valid_q || ready_i;
  assign fire    = valid_i && ready_o;

  // Accumulator with the current beat merged at slot cnt and
  // every slot above it forced to zero (padding on early close).
  always_comb begin
    word = '0;
    for (int s = 0; s < K; s++) begin
      if (s < int'(cnt_q))
        word[s*N +: N] = acc_q[s*N +: N];
      else if (s == int'(cnt_q))
        word[s*N +: N] = data_i;
      else
        word[s*N +: N] = '0;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    data_d  = data_q;
    beats_d = beats_q;
    if (fire && closing) begin
      valid_d = 1'b1;
      data_d  = word;
      beats_d = cnt_q + CW'(1);
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (valid_q && ready_i)
        valid_d = 1'b0;
      if (fire) begin
        acc_d = word;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      beats_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      beats_q <= beats_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign beats_o = beats_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed and random checks of nibble_packer (N=4, K=4)
// against a queue-based reference model of the packing rules.
module tb_nibble_packer;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int CW = $clog2(K+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic [N-1:0]    data_i;
  logic            last_i;
  logic            ready_o;
  logic            valid_o;
  logic [K*N-1:0]  data_o;
  logic [CW-1:0]   beats_o;
  logic            ready_i;

  nibble_packer #(.N(N), .K(K), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .beats_o (beats_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cycles = 0;

  logic [N-1:0]   cur[$];
  logic           m_valid;
  logic [K*N-1:0] m_data;
  int             m_beats;
  logic           m_ready;
  logic           m_fire;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance model, step past posedge.
  task automatic cyc();
    logic closing;
    logic [K*N-1:0] w;
    @(negedge clk);
    closing = (cur.size() == K-1) || last_i;
    m_ready = !closing || !m_valid || ready_i;
    check("ready_o", 32'(ready_o), 32'(m_ready));
    check("valid_o", 32'(valid_o), 32'(m_valid));
    if (m_valid) begin
      check("data_o", 32'(data_o), 32'(m_data));
      check("beats_o", 32'(beats_o), 32'(m_beats));
    end
    m_fire = valid_i && m_ready;
    if (rst) begin
      cur.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_beats = 0;
    end else begin
      if (m_fire)
        cur.push_back(data_i);
      if (m_fire && closing) begin
        w = '0;
        foreach (cur[i])
          w = w | (16'(cur[i]) << (N*i));
        m_data  = w;
        m_beats = cur.size();
        m_valid = 1'b1;
        cur.delete();
      end else if (m_valid && ready_i) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic beat(input logic [N-1:0] d, input logic l);
    int n;
    n = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    do begin
      cyc();
      n++;
    end while (!m_fire && n < 20);
    if (!m_fire) begin
      compared++;
      mismatched++;
      $error("FAIL beat_timeout observed=stuck expected=accept");
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    valid_i = 1'b0;
    data_i = '0;
    last_i = 1'b0;
    ready_i = 1'b1;
    m_valid = 1'b0;
    m_data = '0;
    m_beats = 0;
    m_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_beats", 32'(beats_o), 32'd0);

    // basic pack
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    check("basic_valid", 32'(valid_o), 32'd1);
    check("basic_data", 32'(data_o), 32'h4321);
    check("basic_beats", 32'(beats_o), 32'd4);
    cyc();
    check("basic_drop", 32'(valid_o), 32'd0);

    // early close
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b1);
    check("early_data", 32'(data_o), 32'h00BA);
    check("early_beats", 32'(beats_o), 32'd2);
    cyc();

    // back-pressure
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    ready_i = 1'b0;
    beat(4'h5, 1'b0);
    beat(4'h6, 1'b0);
    beat(4'h7, 1'b0);
    valid_i = 1'b1;
    data_i = 4'h8;
    #1;
    check("bp_ready_low", 32'(ready_o), 32'd0);
    cyc();
    cyc();
    check("bp_hold_data", 32'(data_o), 32'h4321);
    check("bp_hold_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    #1;
    check("bp_ready_high", 32'(ready_o), 32'd1);
    cyc();
    valid_i = 1'b0;
    check("bp_valid", 32'(valid_o), 32'd1);
    check("bp_data", 32'(data_o), 32'h8765);
    check("bp_beats", 32'(beats_o), 32'd4);
    cyc();

    // continuous stream, no bubbles
    c0 = cycles;
    for (int i = 0; i < 16; i++)
      beat(4'(i), 1'b0);
    check("cont_cycles", 32'(cycles - c0), 32'd16);
    check("cont_last", 32'(data_o), 32'hFEDC);
    cyc();

    // reset mid-word
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    beat(4'h5, 1'b0);
    beat(4'h6, 1'b0);
    check("mid_rst_data", 32'(data_o), 32'h6543);
    check("mid_rst_beats", 32'(beats_o), 32'd4);
    cyc();

    // last_i on slot K-1
    beat(4'h9, 1'b0);
    beat(4'h8, 1'b0);
    beat(4'h7, 1'b0);
    beat(4'h6, 1'b1);
    check("lastk_data", 32'(data_o), 32'h6789);
    check("lastk_beats", 32'(beats_o), 32'd4);
    cyc();
    check("lastk_once", 32'(valid_o), 32'd0);

    // random traffic; upstream holds a beat until accepted
    m_fire = 1'b1;
    valid_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(valid_i && !m_fire)) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = 4'($urandom);
        last_i  = ($urandom_range(0, 3) == 0);
      end
      ready_i = ($urandom_range(0, 2) != 0);
      cyc();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream stage for the N-bit valid/ready beat stream produced by the transmitter.
- Collects K consecutive N-bit beats and emits them as one K*N-bit word, first beat in the least-significant slot.
- An optional early-close marker flushes a partial word, zero-padded, together with its beat count.
- Output is a registered valid/ready channel, so the rest of the design consumes whole words instead of nibbles.

## Interface
- N, default 4: input beat width in bits.
- K, default 4: beats per full word; K >= 2.
- CW, default $clog2(K+1): width of the beat-count output.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream beat valid.
- data_i  input  N  upstream beat data.
- last_i  input  1  qualifies data_i as final beat of the current word (early close); sampled only on an accepted beat.
- ready_o  output  1  packer accepts a beat this cycle.
- valid_o  output  1  packed word valid.
- data_o  output  K*N  packed word.
- beats_o  output  CW  number of real beats in data_o, 1..K.
- ready_i  input  1  downstream accepts the packed word.

## Operation
- Beat transfer occurs when valid_i && ready_o. Word transfer occurs when valid_o && ready_i.
- Internal state:
  - accumulator acc[K*N-1:0];
  - beat counter cnt, 0..K-1;
  - output register (valid_o, data_o, beats_o).
- An accepted beat writes data_i into slot cnt, i.e. acc[cnt*N +: N].
- The beat is "closing" if cnt == K-1 or last_i == 1.
- Non-closing beat: cnt increments.
- Closing beat:
  - data_o is loaded with acc, with the current beat merged into slot cnt and all higher slots forced to 0.
  - beats_o is loaded with cnt+1.
  - valid_o is set to 1.
  - cnt returns to 0 and acc clears to 0.
- ready_o = (cnt != K-1 && !last_i) || !valid_o || ready_i.
  - Non-closing beats are always accepted.
  - A closing beat is accepted only if the output register is empty or drains in the same cycle.
  - ready_o has a combinational path from ready_i and last_i; there is no combinational path from data_i to data_o.
- Output register:
  - holds data_o and beats_o stable while valid_o && !ready_i;
  - clears valid_o on a word transfer unless a closing beat is accepted in the same cycle, in which case it reloads.
- State machine, implicit in (cnt, valid_o):
  - FILL: valid_o = 0.
  - FILL+PEND: valid_o = 1, accumulating next word.
  - STALL: valid_o = 1, cnt = K-1, ready_i = 0, so ready_o is low for closing beats.
- last_i on a beat with cnt == K-1 behaves as an ordinary full word: beats_o = K.
- Word arithmetic is fixed width; cnt never exceeds K-1, so there is no wrap beyond that.

## Timing
- Reset values: valid_o = 0, data_o = 0, beats_o = 0, cnt = 0, acc = 0. ready_o = 1 in the first cycle after reset.
- Latency: a closing beat accepted at edge t gives valid_o = 1 with the new word in the cycle after t.
- Throughput: one beat per cycle sustained with ready_i held high, i.e. one word per K cycles with no bubbles.
- Simultaneous word transfer and closing-beat acceptance in one cycle: the old word leaves and the new word loads; valid_o stays 1.
- With valid_o = 1 and ready_i = 0: up to K-1 further non-closing beats are accepted, then ready_o drops for the closing beat.
- Reset mid-operation:
  - rst has priority over all transfers;
  - partial accumulator contents and any pending word are discarded;
  - valid_o = 0 in the next cycle.
- valid_i high with ready_o low: no state change; the upstream holds data_i and last_i.

## Test plan
- Basic pack: N=4, K=4, ready_i = 1, beats 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> one cycle after the 4th beat, valid_o = 1, data_o = 0x4321, beats_o = 4; valid_o = 0 the next cycle.
- Early close: beats 0xA, then 0xB with last_i = 1 -> data_o = 0x00BA, beats_o = 2; the following word starts at slot 0.
- Back-pressure: ready_i = 0 after word 0x4321 is produced; stream 0x5, 0x6, 0x7, 0x8 ->
  - 0x5..0x7 are accepted;
  - ready_o = 0 while 0x8 is presented;
  - data_o stays 0x4321;
  - raise ready_i -> 0x8 is accepted that cycle, and next cycle data_o = 0x8765 with valid_o still 1.
- Continuous stream: 16 beats 0x0..0xF, ready_i = 1 -> four words 0x3210, 0x7654, 0xBA98, 0xFEDC; no cycle with ready_o = 0.
- Reset mid-word: accept 0x1, 0x2, assert rst for one cycle, then send 0x3, 0x4, 0x5, 0x6 -> data_o = 0x6543, beats_o = 4; no trace of 0x1 or 0x2.
- last_i on slot K-1: beats 0x9, 0x8, 0x7, 0x6 with last_i = 1 on the 4th -> data_o = 0x6789, beats_o = 4, exactly one word emitted.
